// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// and queues them in a small buffer in front of decode/control.
//
// state | meaning
// RUN   | no request outstanding; issue when the buffer has room
// WAIT  | request outstanding, address frozen until ack
// DROP  | request outstanding after a redirect; its data is discarded on ack
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        j_signal,
  input  logic [31:0] jump,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc, req_addr, target;
  logic [31:0]      buf_pc   [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             issue, push, pop;

  assign target = {jump[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // A redirect in RUN issues straight to the target: the flush guarantees room.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      RUN: begin
        if (j_signal || (count < FULL_CNT)) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          push      = !j_signal;
          state_nxt = RUN;
        end else if (j_signal) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign imem_req    = (state != RUN);
  assign imem_addr   = req_addr;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && !stall && !j_signal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= j_signal && (jump[1:0] != 2'b00);
      if (j_signal)  fetch_pc <= target;
      else if (push) fetch_pc <= fetch_pc + 32'd4;
      if (issue) req_addr <= j_signal ? target : fetch_pc;
      if (j_signal) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= req_addr;
      buf_data[wr_ptr] <= imem_rdata;
    end
  end

  assign instr    = instr_valid ? buf_data[rd_ptr] : NOP;
  assign pc_out   = instr_valid ? buf_pc[rd_ptr] : RESET_PC;
  assign opcode   = instr[6:0];
  assign pc_plus4 = pc_out + 32'd4;

endmodule
